// File: rtl/axi_arb_pkg.sv
// +----------------------------------------------------------------------+
// | axi_arb_pkg: shared types and helpers for the AXI round-robin        |
// | arbiters.                                        Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  // A single master still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick_n.sv
// +----------------------------------------------------------------------+
// | rr_pick_n: combinational rotating-priority picker; the first         |
// | requester at or above ptr (wrapping) wins.       Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick_n #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  int c;

  // Scan from the farthest candidate back to ptr so the closest one wins last.
  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    c      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        valid     = 1'b1;
        idx       = IDX_W'(c);
        onehot    = '0;
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rr_arbiter_rd_n.sv
// +----------------------------------------------------------------------+
// | axi_rr_arbiter_rd_n: round-robin AXI read arbiter holding the grant  |
// | from AR grant through the last R beat.           Revision: 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module axi_rr_arbiter_rd_n
  import axi_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int BEAT_W      = 9,
  localparam int IDX_W      = idx_w(NUM_MASTERS)
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] m_arvalid,
  input  logic [NUM_MASTERS-1:0] m_rready,
  input  logic                   s_arready,
  input  logic                   s_rvalid,
  input  logic                   s_rlast,
  output logic [NUM_MASTERS-1:0] m_rgrnt,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic [BEAT_W-1:0]      beat_cnt,
  output logic                   err_stray_r
);

  arb_state_e             state;
  logic [IDX_W-1:0]       ptr;
  logic [IDX_W-1:0]       ptr_nxt;
  logic [IDX_W-1:0]       pick_ptr;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] pick_onehot;
  logic                   ar_hs;
  logic                   r_hs;
  logic                   last_beat;

  assign ar_hs     = m_arvalid[grant_idx] & s_arready;
  assign r_hs      = s_rvalid & m_rready[grant_idx];
  assign last_beat = (state == DATA) & r_hs & s_rlast;
  assign ptr_nxt   = IDX_W'(next_idx(int'(grant_idx), NUM_MASTERS));

  // The rotated pointer takes effect in the same cycle for zero-bubble re-arbitration.
  assign pick_ptr = last_beat ? ptr_nxt : ptr;

  rr_pick_n #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (m_arvalid),
    .ptr    (pick_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      ptr         <= '0;
      m_rgrnt     <= '0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      err_stray_r <= 1'b0;
    end else begin
      if (s_rvalid && (state != DATA)) err_stray_r <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= ADDR;
            m_rgrnt   <= pick_onehot;
            grant_idx <= pick_idx;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            state    <= DATA;
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (r_hs && (beat_cnt != {BEAT_W{1'b1}})) beat_cnt <= beat_cnt + BEAT_W'(1);
          if (last_beat) begin
            ptr <= ptr_nxt;
            if (pick_valid) begin
              state     <= ADDR;
              m_rgrnt   <= pick_onehot;
              grant_idx <= pick_idx;
            end else begin
              state   <= IDLE;
              m_rgrnt <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_rgrnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
